// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM state encodings and
// the bit positions of the {N, Z, C, V} flag vector.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_SUB = 3'b100,
      OP_XOR = 3'b101,
      OP_SHL = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Single-cycle ALU operations (NOP..SHL) and their flags. MUL is not handled
// here and yields a zero result; the multi-cycle wrapper owns the multiplier.
module alu_core
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  op_e          op_i,
   output logic [W-1:0] res_o,
   output logic [3:0]   flags_o
);

   localparam int SW = $clog2(W);

   logic [W:0]    wide_s;
   logic [SW-1:0] sh_s;
   logic          c_s;
   logic          v_s;

   // Result is formed one bit wider so the carry, borrow or shifted-out bit lands in wide_s[W].
   always_comb begin
      wide_s = {(W+1){1'b0}};
      c_s    = 1'b0;
      v_s    = 1'b0;
      sh_s   = b_i[SW-1:0];
      case (op_i)
         OP_ADD: begin
            wide_s = {1'b0, a_i} + {1'b0, b_i};
            c_s    = wide_s[W];
            v_s    = (a_i[W-1] == b_i[W-1]) && (wide_s[W-1] != a_i[W-1]);
         end
         OP_SUB: begin
            wide_s = {1'b0, a_i} - {1'b0, b_i};
            c_s    = wide_s[W];
            v_s    = (a_i[W-1] != b_i[W-1]) && (wide_s[W-1] != a_i[W-1]);
         end
         OP_AND: wide_s = {1'b0, a_i & b_i};
         OP_OR:  wide_s = {1'b0, a_i | b_i};
         OP_XOR: wide_s = {1'b0, a_i ^ b_i};
         OP_SHL: begin
            wide_s = {1'b0, a_i} << sh_s;
            c_s    = wide_s[W];
         end
         OP_NOP:  wide_s = {(W+1){1'b0}};
         default: wide_s = {(W+1){1'b0}};
      endcase
      res_o           = wide_s[W-1:0];
      flags_o         = 4'b0000;
      flags_o[FLAG_N] = res_o[W-1];
      flags_o[FLAG_Z] = (res_o == {W{1'b0}});
      flags_o[FLAG_C] = c_s;
      flags_o[FLAG_V] = v_s;
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready in and out, one operation in flight, single-cycle
// ops through alu_core and an unsigned shift-add multiplier taking W cycles.
module alu_mc
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] res,
   output logic [W-1:0] res_hi,
   output logic [3:0]   flags
);

   localparam int CW = $clog2(W + 1);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    mcand_q;
   logic [W-1:0]    res_q;
   logic [W-1:0]    res_hi_q;
   logic [3:0]      flags_q;

   op_e             op_s;
   logic [W-1:0]    core_res_s;
   logic [3:0]      core_flags_s;
   logic [W:0]      mul_sum_s;
   logic [2*W-1:0]  prod_d;
   logic [3:0]      mul_flags_d;

   assign op_s = op_e'(op);

   alu_core #(.W(W)) u_core (
      .a_i     (a),
      .b_i     (b),
      .op_i    (op_s),
      .res_o   (core_res_s),
      .flags_o (core_flags_s)
   );

   // One shift-add step: {res_hi_q, res_q} holds partial product over the unconsumed multiplier bits.
   always_comb begin
      mul_sum_s = {1'b0, res_hi_q};
      if (res_q[0]) begin
         mul_sum_s = {1'b0, res_hi_q} + {1'b0, mcand_q};
      end else begin
         mul_sum_s = {1'b0, res_hi_q};
      end
      prod_d              = {mul_sum_s, res_q[W-1:1]};
      mul_flags_d         = 4'b0000;
      mul_flags_d[FLAG_N] = prod_d[W-1];
      mul_flags_d[FLAG_Z] = (prod_d == {(2*W){1'b0}});
      mul_flags_d[FLAG_C] = (prod_d[2*W-1:W] != {W{1'b0}});
      mul_flags_d[FLAG_V] = 1'b0;
   end

   // Control FSM together with the result, flag and multiplier registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= {CW{1'b0}};
         mcand_q  <= {W{1'b0}};
         res_q    <= {W{1'b0}};
         res_hi_q <= {W{1'b0}};
         flags_q  <= 4'b0000;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  res_hi_q <= {W{1'b0}};
                  if (op_s == OP_MUL) begin
                     cnt_q   <= CW'(W);
                     mcand_q <= a;
                     res_q   <= b;
                     flags_q <= 4'b0000;
                     state_q <= ST_MUL;
                  end else begin
                     res_q   <= core_res_s;
                     flags_q <= core_flags_s;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_MUL: begin
               res_hi_q <= prod_d[2*W-1:W];
               res_q    <= prod_d[W-1:0];
               cnt_q    <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  flags_q <= mul_flags_d;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign res       = res_q;
   assign res_hi    = res_hi_q;
   assign flags     = flags_q;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter W, default 8, operand/result width in bits; legal range 4..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block accepts a new operation.
REQ-006 a  input  W  operand A, unsigned/two's-complement per op.
REQ-007 b  input  W  operand B.
REQ-008 op  input  3  opcode: 000 NOP, 001 ADD, 010 AND, 011 OR, 100 SUB, 101 XOR, 110 SHL, 111 MUL.
REQ-009 out_valid  output  1  result registers hold a completed result.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 res  output  W  result low word.
REQ-012 res_hi  output  W  MUL upper word; zero for all other ops.
REQ-013 flags  output  4  {N, Z, C, V} of completed result.

Function
REQ-014 Transfer in occurs when in_valid and in_ready are both high on a rising edge; a, b, op are captured that edge.
REQ-015 Transfer out occurs when out_valid and out_ready are both high on a rising edge.
REQ-016 FSM states IDLE, MUL, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-017 IDLE: on accept of op != MUL, compute result, register it, go to DONE (out_valid one cycle after accept).
REQ-018 IDLE: on accept of MUL, load iteration counter with W, go to MUL.
REQ-019 MUL: unsigned shift-add, one bit of b per cycle, LSB first; after exactly W cycles in MUL go to DONE; full 2W-bit product on {res_hi, res}.
REQ-020 DONE: hold res, res_hi, flags stable until transfer out, then IDLE; in_ready stays low during DONE (no overlap).
REQ-021 ADD: res = (a+b) mod 2^W; C = carry out; V = signed overflow.
REQ-022 SUB: res = (a-b) mod 2^W; C = 1 when a < b unsigned (borrow); V = signed overflow.
REQ-023 AND/OR/XOR: bitwise; C = V = 0.
REQ-024 SHL: res = a << b[$clog2(W)-1:0]; C = last bit shifted out (0 when shift amount 0); V = 0.
REQ-025 NOP: res = 0, res_hi = 0, flags computed as for a zero result; still produces one output transfer.
REQ-026 MUL: C = 1 when res_hi != 0; V = 0.
REQ-027 N = res[W-1]; Z = (res == 0) for all ops (MUL: Z refers to full 2W-bit product).
REQ-028 in_valid while in_ready low is ignored; operands changing during MUL or DONE do not affect result.
REQ-029 out_ready high while out_valid low has no effect.

Reset
REQ-030 rst_n low forces state IDLE, counter 0, res/res_hi 0, flags 0, out_valid 0 immediately, independent of clk.
REQ-031 Reset asserted mid-MUL or in DONE discards the operation; no output transfer follows.
REQ-032 First accept possible on the first rising edge after rst_n deasserts.

Structure
REQ-033 Package alu_pkg holds opcode enum (3-bit, encodings per REQ-008), FSM state enum, and flag bit index constants.
REQ-034 Sub-module alu_core: purely combinational single-cycle ops (NOP..SHL) plus flag generation, parametrised by W; alu_mc owns FSM, handshake, MUL datapath and output registers.
REQ-035 No latches; all outputs driven from registers except in_ready/out_valid decoded from state register.

Verification
REQ-036 W=8, ADD a=0xFF b=0x01, out_ready=1 -> out_valid next cycle, res=0x00, Z=1 C=1 V=0 N=0.
REQ-037 W=8, SUB a=0x80 b=0x01 -> res=0x7F, V=1, C=0, N=0; SUB a=0x01 b=0x02 -> res=0xFF, C=1, N=1.
REQ-038 W=8, MUL a=0xFF b=0xFF -> out_valid exactly 9 cycles after accept, res_hi=0xFE res=0x01, C=1.
REQ-039 W=8, AND a=0xF0 b=0x0F with out_ready held low 5 cycles -> out_valid and res=0x00 stable all 5 cycles, in_ready low; transfer on out_ready -> in_ready high next cycle.
REQ-040 W=8, SHL a=0x81 b=0x01 -> res=0x02, C=1; opcode changed to ADD during DONE -> result unchanged.
REQ-041 Assert rst_n low in 4th MUL cycle -> all outputs 0 asynchronously, in_ready high after release, no stray out_valid.
